alu_exec_unit: RTL and testbench

- Parametrised successor to the single-cycle ALU control decoder.
- Merges ALU-control decode (aluop/func to ctr) with a registered execute stage.
- Adds iterative multi-cycle MUL and DIVU and valid/ready handshakes on input and output.
- Sits between decode and writeback in the multi-cycle datapath. Single-cycle ops take one cycle; MUL/DIVU stall the input side for WIDTH cycles.

---
 rtl/alu_exec_unit.sv | 208 ++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ALU execute unit: decodes aluop/func into an ALU control code, executes single-cycle
// ops with a registered result, and runs iterative MUL / DIVU behind valid/ready handshakes.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       aluop,
    input  logic [5:0]       func,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [2:0]       ctr,
    output logic             err,
    output logic             busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV} state_e;
    typedef enum logic [1:0] {K_ALU, K_MUL, K_DIV, K_ILL} kind_e;

    localparam logic [2:0] CTR_ADD  = 3'b000;
    localparam logic [2:0] CTR_SUB  = 3'b001;
    localparam logic [2:0] CTR_AND  = 3'b010;
    localparam logic [2:0] CTR_OR   = 3'b011;
    localparam logic [2:0] CTR_XOR  = 3'b100;
    localparam logic [2:0] CTR_NOR  = 3'b101;
    localparam logic [2:0] CTR_SLT  = 3'b110;
    localparam logic [2:0] CTR_SLTU = 3'b111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // opa: multiplicand (MUL) / dividend-then-quotient (DIV); opb: multiplier / divisor;
    // acc: partial product / partial remainder.
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic [2:0]       ctr_q, ctr_d;

    kind_e            dec_kind;
    logic [2:0]       dec_ctr;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;
    logic [WIDTH-1:0] div_quot;
    logic             accept;
    logic             last_iter;

    assign in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // NOTE: every variable assigned in an always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_kind = K_ALU;
        dec_ctr  = aluop;
        if (aluop[2]) begin
            dec_ctr = CTR_ADD;
            unique casez (func)
                6'b10000?: dec_ctr = CTR_ADD;
                6'b10001?: dec_ctr = CTR_SUB;
                6'b100100: dec_ctr = CTR_AND;
                6'b100101: dec_ctr = CTR_OR;
                6'b100110: dec_ctr = CTR_XOR;
                6'b100111: dec_ctr = CTR_NOR;
                6'b101010: dec_ctr = CTR_SLT;
                6'b101011: dec_ctr = CTR_SLTU;
                6'b011000: dec_kind = K_MUL;
                6'b011010: dec_kind = K_DIV;
                default:   dec_kind = K_ILL;
            endcase
        end
    end

    always_comb begin
        alu_res = '0;
        unique case (dec_ctr)
            CTR_ADD:  alu_res = a + b;
            CTR_SUB:  alu_res = a - b;
            CTR_AND:  alu_res = a & b;
            CTR_OR:   alu_res = a | b;
            CTR_XOR:  alu_res = a ^ b;
            CTR_NOR:  alu_res = ~(a | b);
            CTR_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            CTR_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default:  alu_res = '0;
        endcase
        if (dec_kind == K_ILL) alu_res = '0;
    end

    // One shift-add step (LSB of multiplier first) and one restoring-division step
    // (MSB of dividend first). A zero divisor always "fits", giving an all-ones quotient.
    assign mul_acc   = acc_q + (opb_q[0] ? opa_q : '0);
    assign div_shift = {acc_q, opa_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, opb_q});
    assign div_rem   = div_ge ? WIDTH'(div_shift - {1'b0, opb_q}) : div_shift[WIDTH-1:0];
    assign div_quot  = {opa_q[WIDTH-2:0], div_ge};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        result_d    = result_q;
        zero_d      = zero_q;
        err_d       = err_q;
        ctr_d       = ctr_q;
        out_valid_d = out_valid_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (dec_kind == K_MUL || dec_kind == K_DIV) begin
                        opa_d   = a;
                        opb_d   = b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ctr_d   = CTR_ADD;
                        state_d = (dec_kind == K_MUL) ? ST_MUL : ST_DIV;
                    end else begin
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        err_d       = (dec_kind == K_ILL);
                        ctr_d       = dec_ctr;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                acc_d = mul_acc;
                opa_d = opa_q << 1;
                opb_d = opb_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    result_d    = mul_acc;
                    zero_d      = (mul_acc == '0);
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_DIV: begin
                acc_d = div_rem;
                opa_d = div_quot;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    result_d    = div_quot;
                    zero_d      = (div_quot == '0);
                    err_d       = (opb_q == '0);
                    out_valid_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the
    // pre-edge values, regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            err_q       <= 1'b0;
            ctr_q       <= CTR_ADD;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            ctr_q       <= ctr_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign ctr       = ctr_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed and randomized ops compared against
// a behavioural model built from plain arithmetic, plus a scoreboard for streaming.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   aluop;
    logic [5:0]   func;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic [2:0]   ctr;
    logic         err;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         e;
        logic [2:0]   c;
    } exp_t;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .func(func), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ctr(ctr), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: what the operation means, not how the unit computes it.
    function automatic void model(input logic [2:0] op, input logic [5:0] f,
                                  input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic e,
                                  output logic [2:0] c, output logic multi);
        logic [2*W-1:0] prod;
        logic [2:0]     code;
        r = '0; e = 1'b0; c = 3'b000; multi = 1'b0;
        code = op;
        if (op[2]) begin
            if (f == 6'b100000 || f == 6'b100001)      code = 3'd0;
            else if (f == 6'b100010 || f == 6'b100011) code = 3'd1;
            else if (f == 6'b100100) code = 3'd2;
            else if (f == 6'b100101) code = 3'd3;
            else if (f == 6'b100110) code = 3'd4;
            else if (f == 6'b100111) code = 3'd5;
            else if (f == 6'b101010) code = 3'd6;
            else if (f == 6'b101011) code = 3'd7;
            else if (f == 6'b011000) begin
                prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                r = prod[W-1:0]; multi = 1'b1; return;
            end else if (f == 6'b011010) begin
                multi = 1'b1;
                if (y == 0) begin r = '1; e = 1'b1; end
                else r = x / y;
                return;
            end else begin
                e = 1'b1; return;
            end
        end
        c = code;
        case (code)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = x ^ y;
            3'd5: r = ~(x | y);
            3'd6: r = ($signed(x) < $signed(y)) ? 1 : 0;
            default: r = (x < y) ? 1 : 0;
        endcase
    endfunction

    task automatic run_single(input logic [2:0] op, input logic [5:0] f,
                              input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
        logic [W-1:0] r; logic e; logic [2:0] c; logic m;
        model(op, f, x, y, r, e, c, m);
        aluop = op; func = f; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL %s in_ready got %b want 1", tag, in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 1'b1 || result !== r || zero !== (r == 0) || err !== e || ctr !== c) begin
            miscompares++;
            $display("FAIL %s got v=%b res=%h z=%b err=%b ctr=%b want v=1 res=%h z=%b err=%b ctr=%b",
                     tag, out_valid, result, zero, err, ctr, r, (r == 0), e, c);
        end
    endtask

    task automatic run_multi(input logic [5:0] f, input logic [W-1:0] x,
                             input logic [W-1:0] y, input string tag);
        logic [W-1:0] r; logic e; logic [2:0] c; logic m;
        int n;
        model(3'b100, f, x, y, r, e, c, m);
        aluop = 3'b100; func = f; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        // Keep presenting junk while the unit iterates; it must be ignored.
        func = 6'b100000; a = $urandom; b = $urandom;
        n = 0;
        while (out_valid !== 1'b1 && n < 3 * W) begin
            vectors++;
            if (in_ready !== 1'b0 || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s during iteration %0d in_ready=%b busy=%b want 0/1", tag, n, in_ready, busy);
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        vectors++;
        if (n != W) begin miscompares++; $display("FAIL %s latency got %0d want %0d", tag, n, W); end
        vectors++;
        if (out_valid !== 1'b1 || result !== r || err !== e || zero !== (r == 0) || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s got v=%b res=%h err=%b z=%b busy=%b want v=1 res=%h err=%b z=%b busy=0",
                     tag, out_valid, result, err, zero, busy, r, e, (r == 0));
        end
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL %s out_valid after take got %b want 0", tag, out_valid); end
    endtask

    task automatic test_reset();
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        aluop = '0; func = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 || ctr !== 3'b000 || err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values got v=%b res=%h z=%b ctr=%b err=%b busy=%b want 0/0/1/000/0/0",
                     out_valid, result, zero, ctr, err, busy);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        aluop = 3'b100; func = 6'b011000; a = 32'd123; b = 32'd456; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_mul_start busy=%b in_ready=%b want 1/0", busy, in_ready);
        end
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_mul busy=%b v=%b res=%h z=%b want 0/0/0/1", busy, out_valid, result, zero);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_release in_ready=%b v=%b want 1/0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < W + 8; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        vectors++;
        if (seen != 0) begin miscompares++; $display("FAIL reset_abort spurious outputs got %0d want 0", seen); end
    endtask

    task automatic test_add_sub();
        run_single(3'b100, 6'b100000, 32'd7, 32'd5, "add_7_5");
        run_single(3'b100, 6'b100010, 32'd5, 32'd5, "sub_5_5");
        run_single(3'b100, 6'b100001, 32'hFFFF_FFFF, 32'd1, "addu_wrap");
        run_single(3'b001, 6'b000000, 32'd0, 32'd1, "sub_direct_wrap");
    endtask

    task automatic test_compare_logic();
        run_single(3'b100, 6'b101010, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        run_single(3'b100, 6'b101011, 32'hFFFF_FFFF, 32'd1, "sltu_big");
        run_single(3'b010, 6'b111111, 32'd6, 32'd3, "and_direct");
        run_single(3'b100, 6'b100111, 32'h0F0F_0000, 32'h0000_00F0, "nor");
    endtask

    task automatic test_mul();
        run_multi(6'b011000, 32'h0001_0003, 32'h0002_0005, "mul_directed");
        run_multi(6'b011000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_all_ones");
        run_multi(6'b011000, $urandom, $urandom, "mul_random");
    endtask

    task automatic test_div();
        run_multi(6'b011010, 32'd100, 32'd7, "divu_100_7");
        run_multi(6'b011010, 32'd55, 32'd0, "divu_by_zero");
        run_multi(6'b011010, 32'hFFFF_FFFF, 32'd1, "divu_by_one");
        run_multi(6'b011010, 32'd3, 32'd9, "divu_small");
        run_multi(6'b011010, $urandom, {16'h0, 16'($urandom)} | 32'd1, "divu_random");
    endtask

    task automatic test_illegal();
        run_single(3'b100, 6'b111111, 32'd9, 32'd9, "illegal_111111");
        run_single(3'b111, 6'b000000, 32'd1, 32'd2, "illegal_000000");
    endtask

    task automatic test_random_alu();
        logic [5:0] legal [10] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                   6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011};
        logic [5:0] f;
        for (int i = 0; i < 40; i++) begin
            f = (i % 5 == 4) ? 6'($urandom) : legal[$urandom_range(9)];
            if (f == 6'b011000 || f == 6'b011010) f = 6'b111110;
            run_single(3'($urandom), f, $urandom, (i % 7 == 0) ? 32'd0 : $urandom, "random_alu");
        end
    endtask

    task automatic test_backpressure();
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; aluop = 3'b100; func = 6'b100000;
        a = 32'd10; b = 32'd1;
        @(posedge clk); #1;
        a = 32'd20; b = 32'd2;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || result !== 32'd11 || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure_hold cycle %0d v=%b res=%0d in_ready=%b want 1/11/0", i, out_valid, result, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            a = 32'(100 + j); b = 32'(j);
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin miscompares++; $display("FAIL backpressure_stream_ready step %0d got %b want 1", j, in_ready); end
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || result !== 32'(100 + 2 * j)) begin
                miscompares++;
                $display("FAIL backpressure_stream step %0d v=%b res=%0d want 1/%0d", j, out_valid, result, 100 + 2 * j);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL backpressure_drain v=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        exp_t         q[$];
        exp_t         ex, got;
        logic [W-1:0] r; logic e; logic [2:0] c; logic m;
        logic [W-1:0] held;
        logic         hold_chk;
        logic         fire_in;
        logic [5:0]   f;
        hold_chk = 1'b0; held = '0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            out_ready = (cyc >= 296) || ($urandom_range(3) != 0);
            in_valid  = (cyc < 294) && ($urandom_range(3) != 0);
            aluop = 3'($urandom);
            f = 6'($urandom_range(32, 43));
            func = f; a = $urandom; b = $urandom;
            #1;
            vectors++;
            if (out_valid !== (q.size() != 0)) begin
                miscompares++; $display("FAIL b2b_valid cycle %0d got %b want %b", cyc, out_valid, (q.size() != 0));
            end
            if (hold_chk) begin
                vectors++;
                if (result !== held) begin miscompares++; $display("FAIL b2b_hold cycle %0d got %h want %h", cyc, result, held); end
            end
            if (out_valid === 1'b1 && out_ready && q.size() != 0) begin
                ex = q.pop_front();
                got.res = result; got.e = err; got.c = ctr;
                vectors++;
                if (got.res !== ex.res || got.e !== ex.e || got.c !== ex.c || zero !== (ex.res == 0)) begin
                    miscompares++;
                    $display("FAIL b2b_result cycle %0d got res=%h err=%b ctr=%b z=%b want res=%h err=%b ctr=%b",
                             cyc, got.res, got.e, got.c, zero, ex.res, ex.e, ex.c);
                end
            end
            fire_in = in_valid && (in_ready === 1'b1);
            if (fire_in) begin
                model(aluop, func, a, b, r, e, c, m);
                ex.res = r; ex.e = e; ex.c = c;
                q.push_back(ex);
            end
            hold_chk = (out_valid === 1'b1) && !out_ready;
            held = result;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        vectors++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_drain pending=%0d v=%b want 0/0", q.size(), out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_compare_logic();
        test_illegal();
        test_mul();
        test_div();
        test_random_alu();
        test_backpressure();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
